// File: rtl/ldtu_output_fifo_pkg.sv
// Shared LDTU constants for the output FIFO and the control unit, plus the
// per-edge FIFO operation encoding used to update the fill level.
package ldtu_output_fifo_pkg;

    localparam int Nbits_32       = 32;
    localparam int FifoDepth_buff = 64;
    localparam int bits_ptr       = 6;
    localparam logic [31:0] Idle_word = 32'hF000_0000;

    // Bit 0 = accepted write, bit 1 = valid read.
    typedef enum logic [1:0] {
        FIFO_OP_NONE  = 2'b00,
        FIFO_OP_WRITE = 2'b01,
        FIFO_OP_READ  = 2'b10,
        FIFO_OP_BOTH  = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t fifo_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_t'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/ldtu_fifo_mem.sv
// Word storage for the LDTU output FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers decide what is valid.
module ldtu_fifo_mem
    import ldtu_output_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
)(
    input  logic             CLK_,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK_) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ldtu_output_fifo.sv
// LDTU output FIFO between the control unit and the serializer: circular
// buffer with registered read data, idle-word fill, and a sticky overflow flag.
module ldtu_output_fifo
    import ldtu_output_fifo_pkg::*;
#(
    parameter int Nbits_32       = ldtu_output_fifo_pkg::Nbits_32,
    parameter int FifoDepth_buff = ldtu_output_fifo_pkg::FifoDepth_buff,
    parameter int bits_ptr       = ldtu_output_fifo_pkg::bits_ptr,
    parameter logic [Nbits_32-1:0] Idle_word = ldtu_output_fifo_pkg::Idle_word
)(
    input  logic                CLK_,
    input  logic                reset_,
    input  logic                write_signal,
    input  logic [Nbits_32-1:0] DATA_from_CU,
    input  logic                read_signal,
    input  logic                flush,
    output logic [Nbits_32-1:0] DATA_out,
    output logic                full,
    output logic                empty,
    output logic [bits_ptr:0]   fill_level,
    output logic                overflow
);

    localparam logic [bits_ptr:0]   DEPTH_LVL = (bits_ptr+1)'(FifoDepth_buff);
    localparam logic [bits_ptr:0]   LVL_ONE   = (bits_ptr+1)'(1);
    localparam logic [bits_ptr-1:0] PTR_ONE   = bits_ptr'(1);

    logic [bits_ptr-1:0] wr_ptr;
    logic [bits_ptr-1:0] rd_ptr;
    logic [Nbits_32-1:0] rd_word;
    logic                lvl_at_depth;
    logic                wr_accept;
    logic                rd_valid;
    logic                wr_dropped;
    fifo_op_t            op;

    // A write at full depth is only taken when a read frees a slot on the same edge.
    always_comb begin
        lvl_at_depth = (fill_level == DEPTH_LVL);
        wr_accept    = write_signal && (!lvl_at_depth || read_signal);
        rd_valid     = read_signal && (fill_level != '0);
        wr_dropped   = write_signal && !wr_accept;
        op           = fifo_op(wr_accept, rd_valid);
    end

    ldtu_fifo_mem #(
        .WIDTH (Nbits_32),
        .DEPTH (FifoDepth_buff),
        .AW    (bits_ptr)
    ) u_mem (
        .CLK_    (CLK_),
        .wr_en   (wr_accept && !flush && reset_),
        .wr_addr (wr_ptr),
        .wr_data (DATA_from_CU),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge CLK_ or negedge reset_) begin
        if (!reset_) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_valid) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (op)
                FIFO_OP_WRITE: fill_level <= fill_level + LVL_ONE;
                FIFO_OP_READ:  fill_level <= fill_level - LVL_ONE;
                default:       fill_level <= fill_level;
            endcase
        end
    end

    // A read on an empty FIFO emits the idle word; same-edge writes never bypass.
    always_ff @(posedge CLK_ or negedge reset_) begin
        if (!reset_) begin
            DATA_out <= Idle_word;
        end else if (flush) begin
            DATA_out <= Idle_word;
        end else if (read_signal) begin
            DATA_out <= rd_valid ? rd_word : Idle_word;
        end
    end

    always_ff @(posedge CLK_ or negedge reset_) begin
        if (!reset_) begin
            overflow <= 1'b0;
        end else if (!flush && wr_dropped) begin
            overflow <= 1'b1;
        end
    end

    // One word of margin so the control unit's registered strobe cannot overrun.
    assign full  = (fill_level >= (DEPTH_LVL - LVL_ONE));
    assign empty = (fill_level == '0);

endmodule

// File: tb/tb_ldtu_output_fifo.sv
// Scenario bench for ldtu_output_fifo: queue scoreboard of expected read data.
module tb_ldtu_output_fifo;

    localparam logic [31:0] IDLE = 32'hF000_0000;

    logic        CLK_ = 1'b0;
    logic        reset_;
    logic        write_signal;
    logic [31:0] DATA_from_CU;
    logic        read_signal;
    logic        flush;
    logic [31:0] DATA_out;
    logic        full;
    logic        empty;
    logic [6:0]  fill_level;
    logic        overflow;

    logic [31:0] exp_q[$];
    logic [6:0]  m_fill;
    logic [31:0] m_out;
    logic        m_ovf;
    int          n_compared;
    int          n_mismatched;

    always #5 CLK_ = ~CLK_;

    ldtu_output_fifo dut (
        .CLK_         (CLK_),
        .reset_       (reset_),
        .write_signal (write_signal),
        .DATA_from_CU (DATA_from_CU),
        .read_signal  (read_signal),
        .flush        (flush),
        .DATA_out     (DATA_out),
        .full         (full),
        .empty        (empty),
        .fill_level   (fill_level),
        .overflow     (overflow)
    );

    // Drives one edge and updates the reference model / scoreboard.
    task automatic step(input logic wr, input logic [31:0] d, input logic rd);
        logic acc;
        logic do_rd;
        acc   = wr && ((m_fill < 7'd64) || rd);
        do_rd = rd && (m_fill != 7'd0);
        if (do_rd) m_out = exp_q.pop_front();
        else if (rd) m_out = IDLE;
        if (acc) exp_q.push_back(d);
        if (acc && !do_rd) m_fill = m_fill + 7'd1;
        else if (do_rd && !acc) m_fill = m_fill - 7'd1;
        if (wr && !acc) m_ovf = 1'b1;
        write_signal = wr;
        DATA_from_CU = d;
        read_signal  = rd;
        @(posedge CLK_);
        #1;
        write_signal = 1'b0;
        read_signal  = 1'b0;
    endtask

    task automatic test_reset();
        reset_ = 1'b1;
        write_signal = 1'b0; read_signal = 1'b0; flush = 1'b0; DATA_from_CU = '0;
        exp_q.delete(); m_fill = 7'd0; m_out = IDLE; m_ovf = 1'b0;
        #1 reset_ = 1'b0;
        #2;
        n_compared++; if (DATA_out !== IDLE) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h want %h", DATA_out, IDLE); end
        n_compared++; if (fill_level !== 7'd0) begin n_mismatched++; $display("[TB] FAIL reset_fill: got %0d want 0", fill_level); end
        n_compared++; if (empty !== 1'b1 || full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_flags: empty %b full %b want 1 0", empty, full); end
        n_compared++; if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ovf: got %b want 0", overflow); end
        @(posedge CLK_);
        #1 reset_ = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0);
        n_compared++; if (fill_level !== 7'd3) begin n_mismatched++; $display("[TB] FAIL basic_fill: got %0d want 3", fill_level); end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_compared++; if (DATA_out !== m_out || DATA_out !== 32'(i)) begin n_mismatched++; $display("[TB] FAIL basic_read%0d: got %h want %h", i, DATA_out, m_out); end
        end
        n_compared++; if (empty !== 1'b1 || fill_level !== 7'd0) begin n_mismatched++; $display("[TB] FAIL basic_empty: empty %b fill %0d want 1 0", empty, fill_level); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 63; i++) begin
            step(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
            if (i == 61) begin
                n_compared++; if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_at62: got %b want 0", full); end
            end
        end
        n_compared++; if (full !== 1'b1 || fill_level !== 7'd63) begin n_mismatched++; $display("[TB] FAIL full_at63: full %b fill %0d want 1 63", full, fill_level); end
        step(1'b1, 32'hC000_003F, 1'b0);
        n_compared++; if (fill_level !== 7'd64 || overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write64: fill %0d ovf %b want 64 0", fill_level, overflow); end
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        n_compared++; if (fill_level !== 7'd64 || overflow !== 1'b1 || m_ovf !== 1'b1) begin n_mismatched++; $display("[TB] FAIL write65_drop: fill %0d ovf %b want 64 1", fill_level, overflow); end
    endtask

    task automatic test_full_rw();
        step(1'b1, 32'hAAAA_AAAA, 1'b1);
        n_compared++; if (DATA_out !== m_out || DATA_out !== 32'hC000_0000) begin n_mismatched++; $display("[TB] FAIL full_rw_data: got %h want %h", DATA_out, m_out); end
        n_compared++; if (fill_level !== 7'd64 || overflow !== m_ovf) begin n_mismatched++; $display("[TB] FAIL full_rw_state: fill %0d ovf %b want 64 %b", fill_level, overflow, m_ovf); end
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_compared++; if (DATA_out !== m_out) begin n_mismatched++; $display("[TB] FAIL drain%0d: got %h want %h", i, DATA_out, m_out); end
        end
        n_compared++; if (DATA_out !== 32'hAAAA_AAAA || empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_last: data %h empty %b want aaaaaaaa 1", DATA_out, empty); end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 32'h1234_5678, 1'b1);
        n_compared++; if (DATA_out !== IDLE || fill_level !== 7'd1) begin n_mismatched++; $display("[TB] FAIL empty_rw: data %h fill %0d want %h 1", DATA_out, fill_level, IDLE); end
        step(1'b0, 32'h0, 1'b1);
        n_compared++; if (DATA_out !== 32'h1234_5678 || DATA_out !== m_out) begin n_mismatched++; $display("[TB] FAIL empty_rw_next: got %h want 12345678", DATA_out); end
    endtask

    task automatic test_wrap();
        int reads;
        reads = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h5000_0000 + 32'(i), (i % 4) != 0);
            if ((i % 4) != 0) begin
                reads++;
                n_compared++; if (DATA_out !== m_out) begin n_mismatched++; $display("[TB] FAIL wrap_rd%0d: got %h want %h", reads, DATA_out, m_out); end
            end
        end
        for (int k = 0; k < 100 && m_fill != 7'd0; k++) begin
            step(1'b0, 32'h0, 1'b1);
            reads++;
            n_compared++; if (DATA_out !== m_out) begin n_mismatched++; $display("[TB] FAIL wrap_rd%0d: got %h want %h", reads, DATA_out, m_out); end
        end
        n_compared++; if (DATA_out !== 32'h5000_0063 || fill_level !== 7'd0) begin n_mismatched++; $display("[TB] FAIL wrap_end: data %h fill %0d want 50000063 0", DATA_out, fill_level); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h7700_0000 + 32'(i), 1'b0);
        n_compared++; if (fill_level !== 7'd10) begin n_mismatched++; $display("[TB] FAIL pre_flush_fill: got %0d want 10", fill_level); end
        flush = 1'b1; write_signal = 1'b1; read_signal = 1'b1; DATA_from_CU = 32'h9999_9999;
        @(posedge CLK_);
        #1;
        flush = 1'b0; write_signal = 1'b0; read_signal = 1'b0;
        exp_q.delete(); m_fill = 7'd0; m_out = IDLE;
        n_compared++; if (fill_level !== 7'd0 || DATA_out !== IDLE) begin n_mismatched++; $display("[TB] FAIL flush: fill %0d data %h want 0 %h", fill_level, DATA_out, IDLE); end
        n_compared++; if (overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_ovf_kept: got %b want 1", overflow); end
        for (int i = 0; i < 3; i++) step(1'b1, 32'h6600_0000 + 32'(i), 1'b0);
        reset_ = 1'b0;
        #2;
        exp_q.delete(); m_fill = 7'd0; m_out = IDLE; m_ovf = 1'b0;
        n_compared++; if (overflow !== 1'b0 || fill_level !== 7'd0) begin n_mismatched++; $display("[TB] FAIL async_reset: ovf %b fill %0d want 0 0", overflow, fill_level); end
        n_compared++; if (empty !== 1'b1 || full !== 1'b0 || DATA_out !== IDLE) begin n_mismatched++; $display("[TB] FAIL async_reset_out: empty %b full %b data %h", empty, full, DATA_out); end
        #2 reset_ = 1'b1;
        step(1'b1, 32'hBEEF_0001, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        n_compared++; if (DATA_out !== 32'hBEEF_0001 || DATA_out !== m_out || overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL post_reset: data %h ovf %b want beef0001 0", DATA_out, overflow); end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
